bus_arbiter_rr: RTL and testbench

- Round-robin arbiter that shares one downstream slave bus between N clients using the team's req/ack protocol.
- Each client raises req with its data_req held stable. The arbiter forwards that data to the slave and waits for bus_ready. It then returns the slave response and a one-cycle ack to the client.
- Sits between the client blocks and the shared resource. It is the N-client, timeout-protected successor to the two-client arbitration stage.

---
 rtl/bus_arbiter_rr_pkg.sv | 28 ++
 rtl/bus_arbiter_rr_if.sv | 36 +++
 rtl/bus_arbiter_rr_rr_select.sv | 30 +++
 rtl/bus_arbiter_rr.sv | 129 ++++++++++++
 tb/tb_bus_arbiter_rr.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_rr_pkg.sv
// Shared types and sizing helpers for the round-robin bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        GRANT   = ST_GRANT,
        ACK     = ST_ACK,
        RELEASE = ST_RELEASE
    } state_t;

    // Client index width; a single client still needs one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Wait counter width; must hold the value TIMEOUT itself.
    function automatic int cnt_w(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Client-side req/ack bundle plus the shared slave bus of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: slave stalls the arbiter by holding bus_ready low.
interface bus_arbiter_rr_if #(
    parameter int N_CLIENTS      = 2,
    parameter int REQ_DATA_WIDTH = 8,
    parameter int ACK_DATA_WIDTH = 8
);
    import bus_arbiter_pkg::*;

    localparam int ID_W = id_w(N_CLIENTS);

    logic [N_CLIENTS-1:0]                client_req;
    logic [N_CLIENTS*REQ_DATA_WIDTH-1:0] client_data_req;
    logic [N_CLIENTS-1:0]                client_ack;
    logic [ACK_DATA_WIDTH-1:0]           client_data_ack;
    logic                                client_err;
    logic                                bus_valid;
    logic [REQ_DATA_WIDTH-1:0]           bus_data;
    logic [ID_W-1:0]                     bus_id;
    logic                                bus_ready;
    logic [ACK_DATA_WIDTH-1:0]           bus_rdata;

    // Arbiter view.
    modport master (
        input  client_req, client_data_req, bus_ready, bus_rdata,
        output client_ack, client_data_ack, client_err, bus_valid, bus_data, bus_id
    );

    // Environment view: clients and the slave.
    modport slave (
        output client_req, client_data_req, bus_ready, bus_rdata,
        input  client_ack, client_data_ack, client_err, bus_valid, bus_data, bus_id
    );

endinterface

// File: rtl/bus_arbiter_rr_rr_select.sv
// Round-robin picker: first requester at or after ptr, wrapping N-1 -> 0.
// Latency: combinational.
// Backpressure: none; the caller decides when to take the winner.
module rr_select #(
    parameter int N    = 2,
    parameter int ID_W = 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] winner,
    output logic            any_req
);

    int idx;

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        winner  = '0;
        any_req = |req;
        idx     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            for (int j = 0; j < N; j++) begin
                if (j == idx && req[j]) winner = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter sharing one slave bus among N req/ack clients, with timeout.
// Latency: bus_valid the cycle after req is sampled; ack one cycle after bus_ready (>= 4 cycles/txn).
// Backpressure: slave holds bus_ready low; after TIMEOUT cycles the client gets an error ack.
module bus_arbiter_rr
    import bus_arbiter_pkg::*;
#(
    parameter int N_CLIENTS      = 2,
    parameter int REQ_DATA_WIDTH = 8,
    parameter int ACK_DATA_WIDTH = 8,
    parameter int TIMEOUT        = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    bus_arbiter_rr_if.master bif
);

    localparam int ID_W  = id_w(N_CLIENTS);
    localparam int CNT_W = cnt_w(TIMEOUT);
    // Counter value seen on the edge that ends the TIMEOUT-th wait cycle.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t                    state;
    logic [ID_W-1:0]           ptr_q;
    logic [ID_W-1:0]           gnt_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      bus_valid_q;
    logic [REQ_DATA_WIDTH-1:0] bus_data_q;
    logic [N_CLIENTS-1:0]      ack_q;
    logic [ACK_DATA_WIDTH-1:0] data_ack_q;
    logic                      err_q;

    logic [ID_W-1:0]           win;
    logic                      any_req;
    logic [ID_W-1:0]           ptr_nxt;
    logic [REQ_DATA_WIDTH-1:0] win_data;
    logic                      gnt_req;
    logic [N_CLIENTS-1:0]      gnt_onehot;

    rr_select #(
        .N    (N_CLIENTS),
        .ID_W (ID_W)
    ) u_rr_select (
        .req     (bif.client_req),
        .ptr     (ptr_q),
        .winner  (win),
        .any_req (any_req)
    );

    // Winner's data slice, granted client's live req, and ack one-hot for the grant.
    always_comb begin
        win_data   = '0;
        gnt_req    = 1'b0;
        gnt_onehot = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (ID_W'(i) == win)
                win_data = bif.client_data_req[i*REQ_DATA_WIDTH +: REQ_DATA_WIDTH];
            if (ID_W'(i) == gnt_q) begin
                gnt_req       = bif.client_req[i];
                gnt_onehot[i] = 1'b1;
            end
        end
    end

    assign ptr_nxt = (win == ID_W'(N_CLIENTS - 1)) ? '0 : win + 1'b1;

    // Transaction FSM; every output is a register written here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            bus_valid_q <= 1'b0;
            bus_data_q  <= '0;
            ack_q       <= '0;
            data_ack_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_q       <= win;
                        bus_data_q  <= win_data;
                        bus_valid_q <= 1'b1;
                        ptr_q       <= ptr_nxt;
                        cnt_q       <= '0;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    // A response on the timeout edge still counts as success.
                    if (bif.bus_ready) begin
                        bus_valid_q <= 1'b0;
                        data_ack_q  <= bif.bus_rdata;
                        ack_q       <= gnt_onehot;
                        err_q       <= 1'b0;
                        state       <= ACK;
                    end else if (TIMEOUT > 0 && cnt_q == TO_LAST) begin
                        bus_valid_q <= 1'b0;
                        data_ack_q  <= '0;
                        ack_q       <= gnt_onehot;
                        err_q       <= 1'b1;
                        state       <= ACK;
                    end else if (TIMEOUT > 0) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ACK: begin
                    ack_q <= '0;
                    err_q <= 1'b0;
                    state <= RELEASE;
                end
                RELEASE: begin
                    // Hold off until the served client lets go, so it is not re-granted on a stale req.
                    if (!gnt_req) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bif.bus_valid       = bus_valid_q;
    assign bif.bus_data        = bus_data_q;
    assign bif.bus_id          = gnt_q;
    assign bif.client_ack      = ack_q;
    assign bif.client_data_ack = data_ack_q;
    assign bif.client_err      = err_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: scoreboard of expected grants and acks.
// Latency: n/a.
// Backpressure: slave model delays bus_ready by a programmable number of cycles.
module tb_bus_arbiter_rr;

    localparam int N  = 2;
    localparam int W  = 8;
    localparam int AW = 8;
    localparam int TO = 16;

    typedef struct {
        int id;
        int data;
    } gnt_exp_t;

    typedef struct {
        int id;
        int rdata;
        int err;
    } ack_exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bus_arbiter_rr_if #(
        .N_CLIENTS      (N),
        .REQ_DATA_WIDTH (W),
        .ACK_DATA_WIDTH (AW)
    ) bif ();

    bus_arbiter_rr #(
        .N_CLIENTS      (N),
        .REQ_DATA_WIDTH (W),
        .ACK_DATA_WIDTH (AW),
        .TIMEOUT        (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (bif)
    );

    gnt_exp_t gq[$];
    ack_exp_t aq[$];

    int n_chk  = 0;
    int n_pass = 0;

    int         ready_delay;
    int         vcnt;
    int         last_len;
    logic       prev_valid;
    logic [N-1:0] prev_ack;
    bit         auto_drop;
    int         rem[N];
    int         rr_cnt[N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [AW-1:0] rsp(input logic [W-1:0] d);
        return AW'(d ^ 8'hC3);
    endfunction

    task automatic set_data(input int i, input int d);
        bif.client_data_req[i*W +: W] = W'(d);
    endtask

    task automatic push_txn(input int id, input int d, input bit timeout);
        gnt_exp_t g;
        ack_exp_t a;
        g.id = id;  g.data = d;
        a.id = id;  a.rdata = timeout ? 0 : int'(rsp(W'(d)));  a.err = timeout ? 1 : 0;
        gq.push_back(g);
        aq.push_back(a);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"},    {31'b0, bif.bus_valid},  0);
        chk({tag, "_data"},     32'(bif.bus_data),       0);
        chk({tag, "_id"},       32'(bif.bus_id),         0);
        chk({tag, "_ack"},      32'(bif.client_ack),     0);
        chk({tag, "_data_ack"}, 32'(bif.client_data_ack), 0);
        chk({tag, "_err"},      {31'b0, bif.client_err}, 0);
    endtask

    // One cycle: monitor outputs at the negedge, then update clients and slave for the next edge.
    task automatic step();
        gnt_exp_t g;
        ack_exp_t a;
        @(negedge clk);
        if (bif.bus_valid && !prev_valid) begin
            if (gq.size() == 0) chk("unexp_grant", {31'b0, bif.bus_valid}, 0);
            else begin
                g = gq.pop_front();
                chk("bus_id", 32'(bif.bus_id), g.id);
                chk("bus_data", 32'(bif.bus_data), g.data);
            end
            vcnt = 0;
        end
        if (bif.bus_valid) vcnt++;
        if (!bif.bus_valid && prev_valid) last_len = vcnt;

        for (int i = 0; i < N; i++) begin
            if (rr_cnt[i] > 0) begin
                rr_cnt[i]--;
                if (rr_cnt[i] == 0) bif.client_req[i] = 1'b1;
            end
        end

        if (bif.client_ack != '0) begin
            chk("ack_pulse", 32'(prev_ack), 0);
            chk("valid_at_ack", {31'b0, bif.bus_valid}, 0);
            if (aq.size() == 0) chk("unexp_ack", 32'(bif.client_ack), 0);
            else begin
                a = aq.pop_front();
                chk("ack_vec", 32'(bif.client_ack), 32'(1) << a.id);
                chk("ack_data", 32'(bif.client_data_ack), a.rdata);
                chk("ack_err", {31'b0, bif.client_err}, a.err);
            end
            for (int i = 0; i < N; i++) begin
                if (bif.client_ack[i] && auto_drop) begin
                    bif.client_req[i] = 1'b0;
                    if (rem[i] > 0) begin
                        rem[i]--;
                        if (rem[i] > 0) rr_cnt[i] = 2;
                    end
                end
            end
        end
        prev_valid = bif.bus_valid;
        prev_ack   = bif.client_ack;

        if (bif.bus_valid && ready_delay >= 0 && vcnt == ready_delay + 1) begin
            bif.bus_ready = 1'b1;
            bif.bus_rdata = rsp(bif.bus_data);
        end else begin
            bif.bus_ready = 1'b0;
            bif.bus_rdata = AW'($urandom);
        end
    endtask

    task automatic drain(input string tag, input int max);
        for (int k = 0; k < max && (gq.size() != 0 || aq.size() != 0); k++) step();
        chk({tag, "_drain"}, 32'(gq.size() + aq.size()), 0);
        step();
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bif.client_req  = '0;
        bif.bus_ready   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        prev_valid = 1'b0;
        prev_ack   = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n               = 1'b0;
        bif.client_req      = '0;
        bif.client_data_req = '0;
        bif.bus_ready       = 1'b0;
        bif.bus_rdata       = '0;
        ready_delay         = -1;
        vcnt                = 0;
        last_len            = 0;
        prev_valid          = 1'b0;
        prev_ack            = '0;
        auto_drop           = 1'b1;
        for (int i = 0; i < N; i++) begin rem[i] = 0; rr_cnt[i] = 0; end

        repeat (2) @(negedge clk);
        check_zero("rst");
        rst_n = 1'b1;
        step();

        // Single request, slave answers in the third GRANT cycle.
        ready_delay = 2;
        set_data(0, 21);
        chk("t1_valid_pre", {31'b0, bif.bus_valid}, 0);
        bif.client_req[0] = 1'b1;
        push_txn(0, 21, 1'b0);
        step();
        chk("t1_latency", {31'b0, bif.bus_valid}, 1);
        drain("t1", 20);
        chk("t1_len", 32'(last_len), 3);

        // Simultaneous requests right after reset: client 0 first.
        do_reset();
        ready_delay = 0;
        set_data(0, 3);
        set_data(1, 5);
        bif.client_req = 2'b11;
        push_txn(0, 3, 1'b0);
        push_txn(1, 5, 1'b0);
        drain("t2", 30);
        chk("t2_len", 32'(last_len), 1);

        // Continuous requesters: grants alternate 0,1,0,1,0,1.
        set_data(0, 8'h11);
        set_data(1, 8'h22);
        rem[0] = 3;
        rem[1] = 3;
        for (int t = 0; t < 6; t++) push_txn(t % 2, (t % 2) ? 8'h22 : 8'h11, 1'b0);
        bif.client_req = 2'b11;
        drain("t3", 100);

        // Slave never answers: error ack after TIMEOUT GRANT cycles.
        ready_delay = -1;
        set_data(1, 7);
        bif.client_req[1] = 1'b1;
        push_txn(1, 7, 1'b1);
        drain("t4", 60);
        chk("t4_len", 32'(last_len), TO);

        // Response on exactly the last allowed cycle is a normal ack.
        ready_delay = TO - 1;
        set_data(0, 8'h99);
        bif.client_req[0] = 1'b1;
        push_txn(0, 8'h99, 1'b0);
        drain("t5", 60);
        chk("t5_len", 32'(last_len), TO);

        // Reset during GRANT aborts silently and resets the pointer.
        ready_delay = -1;
        set_data(0, 8'h3C);
        bif.client_req[0] = 1'b1;
        begin
            gnt_exp_t g;
            g.id = 0;
            g.data = 8'h3C;
            gq.push_back(g);
        end
        repeat (3) step();
        chk("t6_in_grant", {31'b0, bif.bus_valid}, 1);
        rst_n = 1'b0;
        #1;
        check_zero("t6_rst");
        bif.client_req = '0;
        repeat (2) step();
        rst_n      = 1'b1;
        prev_valid = 1'b0;
        prev_ack   = '0;
        step();
        ready_delay = 0;
        set_data(0, 8'h0A);
        set_data(1, 8'h0B);
        bif.client_req = 2'b11;
        push_txn(0, 8'h0A, 1'b0);
        push_txn(1, 8'h0B, 1'b0);
        drain("t6", 30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
